// File: rtl/multicycle_control_pkg.sv
// Shared constants for the multicycle control path: opcodes, funct codes,
// ALU operation encoding and the controller state encoding.
package multicycle_control_pkg;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_LSW = 3'b010;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [6:0] F7_BASE = 7'b0000000;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_SLL = 3'b011;
    localparam logic [2:0] ALU_SUB = 3'b100;

    typedef enum logic [3:0] {
        ST_RST      = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_EXEC_R   = 4'd3,
        ST_EXEC_I   = 4'd4,
        ST_ALU_WB   = 4'd5,
        ST_MEM_ADDR = 4'd6,
        ST_MEM_RD   = 4'd7,
        ST_MEM_WB   = 4'd8,
        ST_MEM_WR   = 4'd9,
        ST_BRANCH   = 4'd10,
        ST_TRAP     = 4'd11
    } state_t;

endpackage

// File: rtl/multicycle_control_alu_op_decoder.sv
// Maps controller state and instruction fields to the ALU operation, and flags
// whether the instruction in IR is one the controller can execute.
module alu_op_decoder
    import multicycle_control_pkg::*;
(
    input  logic [3:0] state,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [2:0] alu_control,
    output logic       legal
);

    logic [2:0] r_op_s;
    logic       r_legal_s;

    // R-type funct decode, shared by the legality check and EXEC_R
    always_comb begin
        r_op_s    = ALU_ADD;
        r_legal_s = 1'b0;
        if (funct7 == F7_BASE) begin
            case (funct3)
                F3_ADD:  begin r_op_s = ALU_ADD; r_legal_s = 1'b1; end
                F3_OR:   begin r_op_s = ALU_OR;  r_legal_s = 1'b1; end
                F3_SLL:  begin r_op_s = ALU_SLL; r_legal_s = 1'b1; end
                default: begin r_op_s = ALU_ADD; r_legal_s = 1'b0; end
            endcase
        end else begin
            r_op_s    = ALU_ADD;
            r_legal_s = 1'b0;
        end
    end

    // Instruction legality, independent of state
    always_comb begin
        legal = 1'b0;
        case (opcode)
            OP_RTYPE:           legal = r_legal_s;
            OP_ITYPE:           legal = (funct3 == F3_AND);
            OP_LOAD, OP_STORE:  legal = (funct3 == F3_LSW);
            OP_BRANCH:          legal = (funct3 == F3_BNE);
            default:            legal = 1'b0;
        endcase
    end

    // ALU operation per state; states that do not use the ALU leave it at ADD
    always_comb begin
        alu_control = ALU_ADD;
        case (state)
            ST_EXEC_R: alu_control = r_op_s;
            ST_EXEC_I: alu_control = ALU_AND;
            ST_BRANCH: alu_control = ALU_SUB;
            default:   alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM sequencing PC, IR, register file, ALU and the unified
// memory port; tracks retired instructions and sticky illegal/bus-error faults.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int COUNT_W     = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [6:0]         opcode,
    input  logic [2:0]         funct3,
    input  logic [6:0]         funct7,
    input  logic               alu_zero,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               mem_we,
    output logic               iord,
    output logic               ir_write,
    output logic               pc_en,
    output logic               pc_src,
    output logic               reg_write,
    output logic               mem_to_reg,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [2:0]         alu_control,
    output logic               illegal,
    output logic               bus_err,
    output logic [COUNT_W-1:0] retired
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 2);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

    state_t               state_r;
    state_t               state_next_s;
    logic [WAIT_W-1:0]    wait_cnt_r;
    logic [COUNT_W-1:0]   retired_r;
    logic                 illegal_r;
    logic                 bus_err_r;
    logic                 timeout_s;
    logic                 retire_s;
    logic                 illegal_trap_s;
    logic                 timeout_trap_s;
    logic                 legal_s;

    alu_op_decoder u_alu_op_decoder (
        .state       (state_r),
        .opcode      (opcode),
        .funct3      (funct3),
        .funct7      (funct7),
        .alu_control (alu_control),
        .legal       (legal_s)
    );

    // The counter saturates at the limit; a zero limit disables the timeout
    assign timeout_s = (MEM_TIMEOUT != 0) && (wait_cnt_r == WAIT_LIMIT);
    assign retired   = retired_r;
    assign illegal   = illegal_r;
    assign bus_err   = bus_err_r;

    // Next-state and control strobes; mem_ready always beats a coincident timeout
    always_comb begin
        state_next_s   = state_r;
        mem_req        = 1'b0;
        mem_we         = 1'b0;
        iord           = 1'b0;
        ir_write       = 1'b0;
        pc_en          = 1'b0;
        pc_src         = 1'b0;
        reg_write      = 1'b0;
        mem_to_reg     = 1'b0;
        alu_src_a      = 1'b0;
        alu_src_b      = 2'b00;
        retire_s       = 1'b0;
        illegal_trap_s = 1'b0;
        timeout_trap_s = 1'b0;
        case (state_r)
            ST_RST: state_next_s = ST_FETCH;
            ST_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                if (mem_ready) begin
                    ir_write     = 1'b1;
                    pc_en        = 1'b1;
                    state_next_s = ST_DECODE;
                end else if (timeout_s) begin
                    timeout_trap_s = 1'b1;
                    state_next_s   = ST_TRAP;
                end else begin
                    state_next_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                alu_src_b = 2'b10;
                if (!legal_s) begin
                    illegal_trap_s = 1'b1;
                    state_next_s   = ST_TRAP;
                end else begin
                    case (opcode)
                        OP_RTYPE:          state_next_s = ST_EXEC_R;
                        OP_ITYPE:          state_next_s = ST_EXEC_I;
                        OP_LOAD, OP_STORE: state_next_s = ST_MEM_ADDR;
                        OP_BRANCH:         state_next_s = ST_BRANCH;
                        default: begin
                            illegal_trap_s = 1'b1;
                            state_next_s   = ST_TRAP;
                        end
                    endcase
                end
            end
            ST_EXEC_R: begin
                alu_src_a    = 1'b1;
                state_next_s = ST_ALU_WB;
            end
            ST_EXEC_I: begin
                alu_src_a    = 1'b1;
                alu_src_b    = 2'b10;
                state_next_s = ST_ALU_WB;
            end
            ST_ALU_WB: begin
                reg_write    = 1'b1;
                retire_s     = 1'b1;
                state_next_s = ST_FETCH;
            end
            ST_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                if (opcode == OP_STORE) begin
                    state_next_s = ST_MEM_WR;
                end else begin
                    state_next_s = ST_MEM_RD;
                end
            end
            ST_MEM_RD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    state_next_s = ST_MEM_WB;
                end else if (timeout_s) begin
                    timeout_trap_s = 1'b1;
                    state_next_s   = ST_TRAP;
                end else begin
                    state_next_s = ST_MEM_RD;
                end
            end
            ST_MEM_WB: begin
                reg_write    = 1'b1;
                mem_to_reg   = 1'b1;
                retire_s     = 1'b1;
                state_next_s = ST_FETCH;
            end
            ST_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    retire_s     = 1'b1;
                    state_next_s = ST_FETCH;
                end else if (timeout_s) begin
                    timeout_trap_s = 1'b1;
                    state_next_s   = ST_TRAP;
                end else begin
                    state_next_s = ST_MEM_WR;
                end
            end
            ST_BRANCH: begin
                alu_src_a    = 1'b1;
                pc_src       = 1'b1;
                pc_en        = ~alu_zero;
                retire_s     = 1'b1;
                state_next_s = ST_FETCH;
            end
            ST_TRAP: state_next_s = ST_TRAP;
            default: state_next_s = ST_TRAP;
        endcase
    end

    // State register, memory wait counter, retire counter and sticky faults
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_RST;
            wait_cnt_r <= {WAIT_W{1'b0}};
            retired_r  <= {COUNT_W{1'b0}};
            illegal_r  <= 1'b0;
            bus_err_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if (state_next_s != state_r) begin
                wait_cnt_r <= {WAIT_W{1'b0}};
            end else if (!mem_ready && (wait_cnt_r != WAIT_LIMIT)) begin
                wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
            end else begin
                wait_cnt_r <= wait_cnt_r;
            end
            if (retire_s) begin
                retired_r <= retired_r + COUNT_W'(1);
            end
            if (illegal_trap_s) begin
                illegal_r <= 1'b1;
            end
            if (timeout_trap_s) begin
                bus_err_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed scoreboard bench: the driver queues the expected control word per
// cycle, an independent monitor compares it against the DUT on the falling edge.
module tb_multicycle_control;
    import multicycle_control_pkg::*;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [6:0]    opcode = 7'd0;
    logic [2:0]    funct3 = 3'd0;
    logic [6:0]    funct7 = 7'd0;
    logic          alu_zero = 1'b0;
    logic          mem_ready = 1'b0;
    logic          mem_req, mem_we, iord, ir_write, pc_en, pc_src;
    logic          reg_write, mem_to_reg, alu_src_a, illegal, bus_err;
    logic [1:0]    alu_src_b;
    logic [2:0]    alu_control;
    logic [CW-1:0] retired;

    always #5 clk = ~clk;

    multicycle_control #(.COUNT_W(CW), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .alu_zero(alu_zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .iord(iord), .ir_write(ir_write), .pc_en(pc_en), .pc_src(pc_src),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_control(alu_control), .illegal(illegal),
        .bus_err(bus_err), .retired(retired)
    );

    // Control word: req we iord irw pc_en pc_src rw m2r src_a src_b[2] alu[3]
    wire [13:0] act_ctl = {mem_req, mem_we, iord, ir_write, pc_en, pc_src, reg_write,
                           mem_to_reg, alu_src_a, alu_src_b, alu_control};

    localparam logic [13:0] C_ZERO      = 14'd0;
    localparam logic [13:0] C_FETCH_RDY = {1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,3'b000};
    localparam logic [13:0] C_FETCH_NR  = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,3'b000};
    localparam logic [13:0] C_DECODE    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,3'b000};
    localparam logic [13:0] C_EXEC_ADD  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,3'b000};
    localparam logic [13:0] C_EXEC_OR   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,3'b001};
    localparam logic [13:0] C_EXEC_SLL  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,3'b011};
    localparam logic [13:0] C_EXEC_I    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,3'b010};
    localparam logic [13:0] C_ALU_WB    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,3'b000};
    localparam logic [13:0] C_MEM_ADDR  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,3'b000};
    localparam logic [13:0] C_MEM_RD    = {1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000};
    localparam logic [13:0] C_MEM_WB    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,3'b000};
    localparam logic [13:0] C_MEM_WR    = {1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000};
    localparam logic [13:0] C_BR_TAKEN  = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b1,2'b00,3'b100};
    localparam logic [13:0] C_BR_NOT    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,2'b00,3'b100};

    typedef struct {
        string         name;
        logic [13:0]   ctl;
        logic          ill;
        logic          berr;
        logic [CW-1:0] ret;
    } exp_t;

    exp_t          sb[$];
    int            checks = 0;
    int            errors = 0;
    logic [CW-1:0] exp_ret = '0;
    logic          exp_ill = 1'b0;
    logic          exp_berr = 1'b0;

    task automatic push_exp(input string nm, input logic [13:0] c);
        exp_t e;
        e.name = nm; e.ctl = c; e.ill = exp_ill; e.berr = exp_berr; e.ret = exp_ret;
        sb.push_back(e);
    endtask

    task automatic step(input string nm, input logic rdy, input logic zero, input logic [13:0] c);
        @(posedge clk); #1;
        mem_ready = rdy;
        alu_zero  = zero;
        push_exp(nm, c);
    endtask

    task automatic set_ir(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        opcode = op; funct3 = f3; funct7 = f7;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; mem_ready = 1'b1;
        exp_ill = 1'b0; exp_berr = 1'b0; exp_ret = '0;
        push_exp("reset_low", C_ZERO);
        @(posedge clk); #1;
        rst_n = 1'b1;
        push_exp("reset_release", C_ZERO);
    endtask

    task automatic run_r(input string nm, input logic [2:0] f3, input logic [13:0] c_exec);
        step({nm, "_fetch"}, 1'b1, 1'b0, C_FETCH_RDY); set_ir(OP_RTYPE, f3, 7'd0);
        step({nm, "_decode"}, 1'b1, 1'b0, C_DECODE);
        step({nm, "_exec"}, 1'b1, 1'b0, c_exec);
        step({nm, "_wb"}, 1'b1, 1'b0, C_ALU_WB);
        exp_ret = exp_ret + 1'b1;
    endtask

    task automatic run_andi();
        step("andi_fetch", 1'b1, 1'b0, C_FETCH_RDY); set_ir(OP_ITYPE, F3_AND, 7'd0);
        step("andi_decode", 1'b1, 1'b0, C_DECODE);
        step("andi_exec", 1'b1, 1'b0, C_EXEC_I);
        step("andi_wb", 1'b1, 1'b0, C_ALU_WB);
        exp_ret = exp_ret + 1'b1;
    endtask

    task automatic run_bne(input logic zero);
        step("bne_fetch", 1'b1, 1'b0, C_FETCH_RDY); set_ir(OP_BRANCH, F3_BNE, 7'd0);
        step("bne_decode", 1'b1, 1'b0, C_DECODE);
        step("bne_branch", 1'b1, zero, zero ? C_BR_NOT : C_BR_TAKEN);
        exp_ret = exp_ret + 1'b1;
    endtask

    task automatic run_lw(input int waits);
        step("lw_fetch", 1'b1, 1'b0, C_FETCH_RDY); set_ir(OP_LOAD, F3_LSW, 7'd0);
        step("lw_decode", 1'b1, 1'b0, C_DECODE);
        step("lw_addr", 1'b1, 1'b0, C_MEM_ADDR);
        for (int i = 0; i < waits; i++) step("lw_rd_wait", 1'b0, 1'b0, C_MEM_RD);
        step("lw_rd", 1'b1, 1'b0, C_MEM_RD);
        step("lw_wb", 1'b1, 1'b0, C_MEM_WB);
        exp_ret = exp_ret + 1'b1;
    endtask

    task automatic run_sw(input int fwaits, input int wwaits);
        for (int i = 0; i < fwaits; i++) step("sw_fetch_wait", 1'b0, 1'b0, C_FETCH_NR);
        step("sw_fetch", 1'b1, 1'b0, C_FETCH_RDY); set_ir(OP_STORE, F3_LSW, 7'd0);
        step("sw_decode", 1'b1, 1'b0, C_DECODE);
        step("sw_addr", 1'b1, 1'b0, C_MEM_ADDR);
        for (int i = 0; i < wwaits; i++) step("sw_wr_wait", 1'b0, 1'b0, C_MEM_WR);
        step("sw_wr", 1'b1, 1'b0, C_MEM_WR);
        exp_ret = exp_ret + 1'b1;
    endtask

    // Monitor: every cycle with a queued expectation is compared mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (act_ctl !== e.ctl || illegal !== e.ill || bus_err !== e.berr || retired !== e.ret) begin
                    errors++;
                    $display("FAIL %s @%0t: got ctl=%b ill=%b berr=%b ret=%0d, expected ctl=%b ill=%b berr=%b ret=%0d",
                             e.name, $time, act_ctl, illegal, bus_err, retired, e.ctl, e.ill, e.berr, e.ret);
                end
            end
        end
    end

    // Driver: directed instruction sequences
    initial begin
        int k;
        pulse_reset();
        run_r("add", F3_ADD, C_EXEC_ADD);
        run_r("or", F3_OR, C_EXEC_OR);
        run_r("sll", F3_SLL, C_EXEC_SLL);
        run_andi();
        run_bne(1'b1);
        run_bne(1'b0);
        run_lw(3);
        run_sw(0, 0);
        run_sw(2, 3);
        for (int i = 0; i < 7; i++) run_bne(1'b1);
        run_andi();

        // Unsupported opcode parks the controller in TRAP
        step("ill_fetch", 1'b1, 1'b0, C_FETCH_RDY); set_ir(7'b1101111, 3'd0, 7'd0);
        step("ill_decode", 1'b1, 1'b0, C_DECODE);
        exp_ill = 1'b1;
        for (int i = 0; i < 20; i++) step("ill_trap", i[0], ~i[0], C_ZERO);
        pulse_reset();

        // Memory stuck not-ready during FETCH must end in a bus error
        for (int i = 0; i < 4; i++) step("to_fetch_wait", 1'b0, 1'b0, C_FETCH_NR);
        k = 0;
        while (!bus_err && k < 8) begin
            @(posedge clk); #1;
            k++;
        end
        checks++;
        if (bus_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_bus_err: got bus_err=%b, expected 1 within 8 cycles", bus_err);
        end
        exp_berr = 1'b1;
        for (int i = 0; i < 3; i++) step("to_trap", 1'b1, 1'b0, C_ZERO);
        pulse_reset();

        // Reset asserted while a load waits in MEM_RD
        run_r("add2", F3_ADD, C_EXEC_ADD);
        step("lw2_fetch", 1'b1, 1'b0, C_FETCH_RDY); set_ir(OP_LOAD, F3_LSW, 7'd0);
        step("lw2_decode", 1'b1, 1'b0, C_DECODE);
        step("lw2_addr", 1'b1, 1'b0, C_MEM_ADDR);
        step("lw2_rd_wait", 1'b0, 1'b0, C_MEM_RD);
        pulse_reset();
        run_r("add3", F3_ADD, C_EXEC_ADD);

        @(posedge clk);
        @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
